mono_data_rx_multi: RTL

MONO_DATA_RX_MULTI -- requirements
Module: mono_data_rx_multi

---
 rtl/mono_data_rx_multi.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mono_data_rx_multi.sv
// Multi-channel serial hit receiver: round-robin token arbitration, freeze/read/shift
// sequencing per channel, optional gray decode of timestamps, FWFT output FIFO.
module mono_data_rx_multi #(
  parameter int NCH    = 4,
  parameter int DWIDTH = 30,
  parameter int TSW    = 8,
  parameter int DEPTH  = 16,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  CLK_BX,
  input  logic                  RST_N,
  input  logic [NCH-1:0]        CONF_EN,
  input  logic                  CONF_GRAY_DIS,
  input  logic [7:0]            CONF_FREEZE_DLY,
  input  logic [7:0]            CONF_READ_LEN,
  input  logic [NCH-1:0]        RX_TOKEN,
  input  logic [NCH-1:0]        RX_DATA,
  output logic [NCH-1:0]        RX_READ,
  output logic [NCH-1:0]        RX_FREEZE,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [CHW+DWIDTH-1:0] OUT_DATA,
  output logic [7:0]            LOST_CNT,
  output logic                  BUSY
);

  localparam int CNTW = ($clog2(DWIDTH) > 8) ? $clog2(DWIDTH) : 8;
  localparam int AW   = $clog2(DEPTH);
  localparam int RCW  = DWIDTH - 2 * TSW;
  localparam int OW   = CHW + DWIDTH;

  typedef enum logic [2:0] {IDLE, FREEZE, READ, SHIFT, STORE} state_t;

  state_t            state_reg, state_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic [CHW-1:0]    sel_reg, sel_next;
  logic [CHW-1:0]    ptr_reg, ptr_next;
  logic [DWIDTH-1:0] shift_reg, shift_next;
  logic [NCH-1:0]    read_reg, freeze_reg;
  logic [NCH-1:0]    elig, sel_onehot;
  logic              elig_any;
  logic [CHW-1:0]    elig_sel;

  logic [OW-1:0]     mem [DEPTH];
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg, fill;
  logic [7:0]        lost_reg;
  logic              fifo_full, do_pop, do_push, store_now;
  logic [DWIDTH-1:0] word_dec;

  // A programmed length of zero still spends one cycle in the state.
  function automatic logic [CNTW-1:0] len_m1(input logic [7:0] v);
    return (v == 8'd0) ? '0 : CNTW'(v - 8'd1);
  endfunction

  function automatic logic [TSW-1:0] gray2bin(input logic [TSW-1:0] g);
    logic [TSW-1:0] b;
    b[TSW-1] = g[TSW-1];
    for (int k = TSW - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  assign elig       = RX_TOKEN & CONF_EN;
  assign sel_onehot = NCH'(1) << sel_reg;

  // Rotate eligibility so bit 0 corresponds to ptr, then take the first set bit.
  always_comb begin : rr_arb
    logic [2*NCH-1:0] dbl;
    logic [CHW:0]     pos;
    dbl      = {elig, elig} >> ptr_reg;
    pos      = '0;
    elig_any = 1'b0;
    elig_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!elig_any && dbl[k]) begin
        elig_any = 1'b1;
        pos      = {1'b0, ptr_reg} + (CHW+1)'(k);
        if (pos >= (CHW+1)'(NCH)) pos = pos - (CHW+1)'(NCH);
        elig_sel = pos[CHW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: begin
        if (elig_any) begin
          state_next = FREEZE;
          sel_next   = elig_sel;
          cnt_next   = len_m1(CONF_FREEZE_DLY);
        end
      end
      FREEZE: begin
        if (cnt_reg == '0) begin
          state_next = READ;
          cnt_next   = len_m1(CONF_READ_LEN);
        end else begin
          cnt_next = cnt_reg - CNTW'(1);
        end
      end
      READ: begin
        if (cnt_reg == '0) begin
          state_next = SHIFT;
          cnt_next   = CNTW'(DWIDTH - 1);
        end else begin
          cnt_next = cnt_reg - CNTW'(1);
        end
      end
      SHIFT: begin
        shift_next = {shift_reg[DWIDTH-2:0], RX_DATA[sel_reg]};
        if (cnt_reg == '0) state_next = STORE;
        else cnt_next = cnt_reg - CNTW'(1);
      end
      STORE: begin
        state_next = IDLE;
        ptr_next   = (sel_reg == CHW'(NCH - 1)) ? '0 : sel_reg + CHW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_BX or negedge RST_N) begin
    if (!RST_N) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      sel_reg    <= '0;
      ptr_reg    <= '0;
      shift_reg  <= '0;
      read_reg   <= '0;
      freeze_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sel_reg    <= sel_next;
      ptr_reg    <= ptr_next;
      shift_reg  <= shift_next;
      read_reg   <= (state_reg == READ) ? sel_onehot : '0;
      freeze_reg <= (state_reg != IDLE) ? sel_onehot : '0;
    end
  end

  assign word_dec = CONF_GRAY_DIS ? shift_reg :
                    {gray2bin(shift_reg[DWIDTH-1 -: TSW]),
                     gray2bin(shift_reg[DWIDTH-TSW-1 -: TSW]),
                     shift_reg[RCW-1:0]};

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign fill      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_full = (fill == (AW+1)'(DEPTH));
  assign OUT_VALID = (fill != '0);
  assign do_pop    = OUT_VALID & OUT_READY;
  assign store_now = (state_reg == STORE);
  assign do_push   = store_now & (~fifo_full | do_pop);

  always_ff @(posedge CLK_BX) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= {sel_reg, word_dec};
  end

  always_ff @(posedge CLK_BX or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      lost_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      if (store_now && !do_push && lost_reg != 8'hFF) lost_reg <= lost_reg + 8'd1;
    end
  end

  assign OUT_DATA  = mem[rd_ptr_reg[AW-1:0]];
  assign LOST_CNT  = lost_reg;
  assign RX_READ   = read_reg;
  assign RX_FREEZE = freeze_reg;
  assign BUSY      = (state_reg != IDLE);

endmodule
